// File: rtl/rfid6c_pkg.sv
// Shared types and default timing constants for the 6C tag front-end blocks.
package rfid6c_pkg;

  localparam int DEF_CNT_W      = 14;
  localparam int DEF_DLM_MIN    = 590;
  localparam int DEF_DLM_MAX    = 660;
  localparam int DEF_TARI_MAX   = 1310;
  localparam int DEF_GLITCH_LEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DLM,
    ST_D0,
    ST_RTC,
    ST_FIRST,
    ST_BITS
  } pie_state_e;

endpackage

// File: rtl/pie_edge_sync.sv
// Synchronizes rd_data and produces registered rise/fall pulses plus the aligned level.
// Optional glitch filter enabled by PIE_GLITCH_FLT_EN.
module pie_edge_sync #(
`ifdef PIE_GLITCH_FLT_EN
  parameter int GLITCH_LEN = 4
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall,
  output logic lvl
);

  logic [1:0] sync;
  logic       src;
  logic       prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], din};
  end

`ifdef PIE_GLITCH_FLT_EN
  localparam int GW = $clog2(GLITCH_LEN + 1);
  logic [GW-1:0] gcnt;
  logic          flt;

  // flt follows sync only after GLITCH_LEN consecutive cycles of disagreement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt <= '0;
      flt  <= 1'b0;
    end else if (sync[1] == flt) begin
      gcnt <= '0;
    end else if (gcnt == GW'(GLITCH_LEN - 1)) begin
      flt  <= sync[1];
      gcnt <= '0;
    end else begin
      gcnt <= gcnt + 1'b1;
    end
  end

  assign src = flt;
`else
  assign src = sync[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      prev <= src;
      rise <= src & ~prev;
      fall <= ~src & prev;
    end
  end

  assign lvl = prev;

endmodule

// File: rtl/pie_decoder.sv
// PIE command decoder: delimiter/Tari/RTcal/TRcal measurement and bit slicing at RTcal/2.
// Define PIE_GLITCH_FLT_EN to insert the input glitch filter.
module pie_decoder
  import rfid6c_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int DLM_MIN  = DEF_DLM_MIN,
  parameter int DLM_MAX  = DEF_DLM_MAX,
  parameter int TARI_MAX = DEF_TARI_MAX
`ifdef PIE_GLITCH_FLT_EN
  , parameter int GLITCH_LEN = DEF_GLITCH_LEN
`endif
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             rd_data,
  input  logic             sys_rst,
  output logic             bit_dat,
  output logic             bit_vld,
  output logic             frm_start,
  output logic             preamble,
  output logic             frm_end,
  output logic             frm_err,
  output logic [CNT_W-1:0] rtcal,
  output logic [CNT_W-1:0] trcal
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] DMIN    = CNT_W'(DLM_MIN);
  localparam logic [CNT_W-1:0] DMAX    = CNT_W'(DLM_MAX);
  localparam logic [CNT_W-1:0] TMAX    = CNT_W'(TARI_MAX);

  pie_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, ivl, tari;
  logic             rise, fall, lvl, sat;
  logic             clr, emit, start_now, err_now, end_now;
  logic             cap_tari, cap_rtcal, cap_trcal, cap_nopre, start_pend;

  pie_edge_sync #(
`ifdef PIE_GLITCH_FLT_EN
    .GLITCH_LEN(GLITCH_LEN)
`endif
  ) u_sync (
    .clk  (clk_50m),
    .rst_n(rst_n),
    .din  (rd_data),
    .rise (rise),
    .fall (fall),
    .lvl  (lvl)
  );

  // cnt is cleared on the edge cycle, so the interval seen this cycle includes it
  assign sat = (cnt == CNT_MAX);
  assign ivl = sat ? cnt : cnt + 1'b1;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (sys_rst) begin
      state_nxt = ST_IDLE;
    end else if (state != ST_IDLE && sat) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (fall) state_nxt = ST_DLM;
        ST_DLM: begin
          if (rise)            state_nxt = (ivl >= DMIN && ivl <= DMAX) ? ST_D0 : ST_IDLE;
          else if (ivl > DMAX) state_nxt = ST_IDLE;
        end
        ST_D0: begin
          if (ivl > TMAX) state_nxt = ST_IDLE;
          else if (rise)  state_nxt = ST_RTC;
        end
        ST_RTC:   if (rise) state_nxt = (ivl > tari) ? ST_FIRST : ST_IDLE;
        ST_FIRST: if (rise) state_nxt = ST_BITS;
        ST_BITS:  if (!rise && ivl >= rtcal) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    clr       = 1'b0;
    emit      = 1'b0;
    start_now = 1'b0;
    err_now   = 1'b0;
    end_now   = 1'b0;
    cap_tari  = 1'b0;
    cap_rtcal = 1'b0;
    cap_trcal = 1'b0;
    cap_nopre = 1'b0;
    if (!sys_rst) begin
      if (state != ST_IDLE && sat) begin
        err_now = 1'b1;
      end else begin
        case (state)
          ST_IDLE: clr = fall;
          ST_DLM:  clr = rise;
          ST_D0: begin
            if (ivl > TMAX) err_now = 1'b1;
            else if (rise) begin
              cap_tari = 1'b1;
              clr      = 1'b1;
            end
          end
          ST_RTC: begin
            if (rise) begin
              if (ivl > tari) begin
                cap_rtcal = 1'b1;
                clr       = 1'b1;
              end else begin
                err_now = 1'b1;
              end
            end
          end
          ST_FIRST: begin
            if (rise) begin
              clr = 1'b1;
              if (ivl > rtcal) begin
                cap_trcal = 1'b1;
              end else begin
                cap_nopre = 1'b1;
                emit      = 1'b1;
                start_now = 1'b1;
              end
            end
          end
          ST_BITS: begin
            if (rise) begin
              clr       = 1'b1;
              emit      = 1'b1;
              start_now = start_pend;
            end else if (ivl >= rtcal) begin
              end_now = lvl;
              err_now = ~lvl;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      tari       <= '0;
      rtcal      <= '0;
      trcal      <= '0;
      preamble   <= 1'b0;
      start_pend <= 1'b0;
      bit_dat    <= 1'b0;
      bit_vld    <= 1'b0;
      frm_start  <= 1'b0;
      frm_end    <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      bit_vld   <= emit;
      frm_start <= start_now;
      frm_end   <= end_now;
      frm_err   <= err_now;
      if (emit) bit_dat <= (ivl > (rtcal >> 1));
      if (sys_rst || clr) cnt <= '0;
      else if (!sat)      cnt <= cnt + 1'b1;
      if (cap_tari) tari <= ivl;
      if (cap_rtcal) begin
        rtcal      <= ivl;
        start_pend <= 1'b0;
      end
      if (cap_trcal) begin
        trcal      <= ivl;
        preamble   <= 1'b1;
        start_pend <= 1'b1;
      end
      if (cap_nopre) begin
        trcal    <= '0;
        preamble <= 1'b0;
      end
      if (start_now) start_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pie_decoder.sv
// Directed bench for pie_decoder: preamble/frame-sync frames, bad delimiter, timeouts, aborts.
module tb_pie_decoder;

  localparam int CNT_W = 14;
  localparam int PW    = 250;
`ifdef PIE_GLITCH_FLT_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 4;
`endif

  logic             clk_50m = 1'b0;
  logic             rst_n   = 1'b0;
  logic             rd_data = 1'b1;
  logic             sys_rst = 1'b0;
  logic             bit_dat, bit_vld, frm_start, preamble, frm_end, frm_err;
  logic [CNT_W-1:0] rtcal, trcal;

  int n_vec  = 0;
  int n_miss = 0;

  int          cyc = 0;
  int          n_bits = 0, n_start = 0, n_sok = 0, n_end = 0, n_ferr = 0, last_vld = 0;
  logic [63:0] bits_sr = '0;
  int          b0, s0, k0, e0, f0, t_rise;

  pie_decoder dut (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .rd_data  (rd_data),
    .sys_rst  (sys_rst),
    .bit_dat  (bit_dat),
    .bit_vld  (bit_vld),
    .frm_start(frm_start),
    .preamble (preamble),
    .frm_end  (frm_end),
    .frm_err  (frm_err),
    .rtcal    (rtcal),
    .trcal    (trcal)
  );

  always #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m) cyc <= cyc + 1;

  always @(negedge clk_50m) begin
    if (bit_vld) begin
      n_bits++;
      bits_sr  = {bits_sr[62:0], bit_dat};
      last_vld = cyc;
    end
    if (frm_start) begin
      n_start++;
      if (bit_vld) n_sok++;
    end
    if (frm_end) n_end++;
    if (frm_err) n_ferr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic lv, input int n);
    rd_data = lv;
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  task automatic sym(input int len);
    drive(1'b1, len - PW);
    drive(1'b0, PW);
  endtask

  task automatic head(input bit pre);
    drive(1'b1, 100);
    drive(1'b0, 625);
    sym(625);
    sym(1719);
    if (pre) sym(3438);
  endtask

  task automatic snap();
    b0 = n_bits; s0 = n_start; k0 = n_sok; e0 = n_end; f0 = n_ferr;
  endtask

  task automatic tail();
    t_rise = cyc;
    drive(1'b1, 1760);
  endtask

  task automatic check_frame(input string tag, input int nb, input logic [3:0] bits,
                             input int ns, input int ne, input int nf);
    check({tag, ".nbits"}, n_bits - b0, nb);
    if (nb > 0) check({tag, ".bits"}, bits_sr[3:0] & ((4'b1 << nb) - 4'b1), bits);
    check({tag, ".start"}, n_start - s0, ns);
    check({tag, ".start_w_bit"}, n_sok - k0, ns);
    check({tag, ".end"}, n_end - e0, ne);
    check({tag, ".err"}, n_ferr - f0, nf);
  endtask

  initial begin
    repeat (3) @(posedge clk_50m);
    #1;
    check("rst.outs", {bit_dat, bit_vld, frm_start, preamble, frm_end, frm_err}, 0);
    check("rst.rtcal", rtcal, 0);
    check("rst.trcal", trcal, 0);
    rst_n = 1'b1;
    drive(1'b1, 20);

    // 1: preamble frame, bits 0110
    snap();
    head(1'b1); sym(625); sym(1094); sym(1094); sym(625); tail();
    check_frame("pre", 4, 4'b0110, 1, 1, 0);
    check("pre.preamble", preamble, 1);
    check("pre.trcal", trcal, 3438);
    check("pre.rtcal", rtcal, 1719);
    check("pre.latency", last_vld - t_rise, LAT);

    // 2: frame-sync, bits 0110
    snap();
    head(1'b0); sym(625); sym(1094); sym(1094); sym(625); tail();
    check_frame("fsync", 4, 4'b0110, 1, 1, 0);
    check("fsync.preamble", preamble, 0);
    check("fsync.trcal", trcal, 0);

    // 3: short delimiter is ignored
    snap();
    drive(1'b1, 100); drive(1'b0, 500);
    sym(625); sym(1719); sym(625); sym(1094); tail();
    check_frame("shortdlm", 0, 4'b0, 0, 0, 0);

    // 4: long low in BITS aborts, next frame still decodes
    snap();
    head(1'b0); sym(625); drive(1'b1, 375); drive(1'b0, 2000); drive(1'b1, 200);
    check_frame("longlow", 1, 4'b0, 1, 0, 1);
    snap();
    head(1'b0); sym(1094); sym(625); sym(625); sym(1094); tail();
    check_frame("recover", 4, 4'b1001, 1, 1, 0);

    // 5: sys_rst after the second bit
    snap();
    head(1'b0); sym(625); sym(1094);
    drive(1'b1, 10);
    sys_rst = 1'b1;
    drive(1'b1, 1);
    sys_rst = 1'b0;
    drive(1'b1, 1094 - PW - 11); drive(1'b0, PW); sym(625); tail();
    check_frame("sysrst", 2, 4'b01, 1, 0, 0);
    check("sysrst.rtcal", rtcal, 1719);

    // 6: slicing at the pivot
    snap();
    head(1'b0); sym(859); sym(860); tail();
    check_frame("pivot", 2, 4'b01, 1, 1, 0);

`ifdef PIE_GLITCH_FLT_EN
    snap();
    head(1'b1); sym(625);
    drive(1'b1, 100); drive(1'b0, 2); drive(1'b1, 1094 - PW - 102); drive(1'b0, PW);
    sym(1094); sym(625); tail();
    check_frame("glitch", 4, 4'b0110, 1, 1, 0);
`endif

    // async reset mid-frame
    head(1'b1);
    drive(1'b1, 50);
    check("arst.pre_trcal", trcal, 3438);
    #3 rst_n = 1'b0;
    #2;
    check("arst.rtcal", rtcal, 0);
    check("arst.trcal", trcal, 0);
    check("arst.preamble", preamble, 0);
    #4 rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pie_decoder.md
Name: pie_decoder

Overview:
- PIE (pulse-interval-encoding) command decoder for the 6C (EPC Gen2) tag front end, sitting directly downstream of the demodulated `rd_data` line, in parallel with the long-low reset detector.
- Detects the delimiter, then measures data-0 (Tari), RTcal and, for a preamble, TRcal.
- Slices each subsequent symbol against pivot = RTcal/2 and emits a serial bit stream with frame start, end and error strobes to the command parser.

Parameters:
- CNT_W, 14, interval counter width (covers TRcal up to 225 us at 50 MHz).
- DLM_MIN, 590, minimum delimiter low length in clk cycles.
- DLM_MAX, 660, maximum delimiter low length in clk cycles.
- TARI_MAX, 1310, maximum accepted data-0 interval in cycles.
- GLITCH_LEN, 4, filter depth in cycles (used only with the optional feature).

Ports:
- clk_50m  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- rd_data  in  1  demodulated reader envelope, asynchronous to clk_50m
- sys_rst  in  1  level; synchronous abort from the reset detector
- bit_dat  out  1  decoded bit, valid when bit_vld=1
- bit_vld  out  1  one-cycle strobe per decoded bit
- frm_start  out  1  one-cycle strobe, coincident with the first bit_vld of a frame
- preamble  out  1  level; 1 = frame began with TRcal; held until next frm_start
- frm_end  out  1  one-cycle strobe at end of command
- frm_err  out  1  one-cycle strobe on timing violation
- rtcal  out  CNT_W  last captured RTcal, in cycles
- trcal  out  CNT_W  last captured TRcal, in cycles; 0 if the frame had no preamble

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0.
- Input conditioning: 2-flop synchronizer, then rise/fall edge detect.
  - Edge pulse occurs 3 clk after an rd_data transition.
- Interval measurement: the counter clears on each detected edge of interest.
  - A captured interval equals the exact number of clk cycles between two detected rising edges.
  - The counter saturates at all-ones; saturation in any non-IDLE state causes frm_err and a return to IDLE.
- IDLE: on a fall, go to DLM and clear the counter.
- DLM (measuring low):
  - Rise with DLM_MIN ≤ cnt ≤ DLM_MAX: go to D0 and clear the counter.
  - Rise outside that window: go to IDLE with no error.
  - cnt > DLM_MAX while still low: go to IDLE silently. Long lows belong to the reset detector.
- D0:
  - Next rise: tari := cnt; go to RTC.
  - cnt > TARI_MAX: frm_err, IDLE.
- RTC:
  - Next rise with cnt > tari: rtcal := cnt; go to FIRST.
  - Otherwise: frm_err, IDLE.
- FIRST, on the next rise:
  - If cnt > rtcal: trcal := cnt, preamble := 1; go to BITS. The first bit comes from the next symbol.
  - Else: trcal := 0, preamble := 0; emit a bit from this interval; go to BITS.
  - frm_start pulses in the same cycle as the first bit_vld in both cases.
- BITS:
  - Each rise: bit_dat := (cnt > rtcal>>1); bit_vld=1 for one cycle in the cycle after the edge pulse.
  - Line high and cnt reaches rtcal: frm_end pulse, IDLE.
  - Line low and cnt reaches rtcal: frm_err, IDLE.
- Pipeline latency: rd_data rise to bit_vld is 4 clk.
- sys_rst=1 in any state:
  - Synchronous return to IDLE and counter clear.
  - bit_vld, frm_start, frm_end and frm_err are forced 0 with no error pulse.
  - rtcal, trcal and preamble hold their values.
- A new delimiter is only recognised from IDLE. A fall in BITS is part of the symbol.
- Async rst_n mid-frame: immediate return to the reset state.

Optional Feature:
- PIE_GLITCH_FLT_EN defined: a glitch filter sits after the synchronizer.
  - The filtered level changes only after the synchronized input has been stable for GLITCH_LEN consecutive cycles.
  - All edges and intervals are shifted by GLITCH_LEN; measured intervals are unchanged.
  - Pulses shorter than GLITCH_LEN are ignored.
- Not defined: the filter is absent, and the raw synchronized level drives the edge detect (latency 4 clk).

Decomposition:
- Shared package rfid6c_pkg holds:
  - state encoding (IDLE, DLM, D0, RTC, FIRST, BITS);
  - CNT_W and the DLM_MIN/DLM_MAX/TARI_MAX default constants.
- One sub-module, pie_edge_sync, covers the synchronizer, the optional glitch filter and rise/fall pulse generation. The FSM, counter and slicer stay in pie_decoder.

Test Plan:
1. Delimiter 625 low, data-0 625, RTcal 1719, TRcal 3438, bits 0,1,1,0 (625/1094/1094/625), then high ≥ 1719 → preamble=1, trcal=3438, rtcal=1719, four bit_vld 0110, frm_start with first bit, single frm_end.
2. Same frame without TRcal (frame-sync) → preamble=0, trcal=0, frm_start with first bit, bits 0110, frm_end.
3. Delimiter 500 low, then valid symbols → no strobes, state stays IDLE.
4. Line held low 1719 cycles mid-BITS → single frm_err, no frm_end, next valid frame decodes normally.
5. sys_rst asserted for 1 cycle after the second bit → no further bit_vld, no frm_err/frm_end, rtcal still 1719.
6. Bit interval exactly 859 (=pivot) → bit_dat=0; 860 → bit_dat=1. With PIE_GLITCH_FLT_EN, a 2-cycle low glitch inside a high → ignored, bits unchanged.
